id_ex_stage: RTL and testbench

Registered ID/EX boundary of the five-stage MIPS pipeline, sitting directly downstream of the control unit and register file. Each cycle it captures the decoded control word (RegDst, branch, Memread, MemtoReg, ALUop, MemWrite, AluSrc, RegWrite), operand data, the sign-extended immediate and register specifiers, and presents them to the EX stage. It detects load-use hazards against the instruction currently in EX, inserts a one-cycle bubble, and stalls PC and IF/ID. It also squashes the incoming instruction on a branch flush and counts hazard bubbles.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 16 +
 rtl/id_ex_stage.sv | 97 +++++++++
 tb/tb_id_ex_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcodes, ALUop encodings, default widths and the control word
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_R     = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hz
);
  // both ID specifiers are compared even when rt is only a write target
  assign hz = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, branch squash
// and a saturating count of hazard bubbles
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic              i_RegDst,
  input  logic              i_branch,
  input  logic              i_Memread,
  input  logic              i_MemtoReg,
  input  logic              i_MemWrite,
  input  logic              i_AluSrc,
  input  logic              i_RegWrite,
  input  logic [3:0]        i_ALUop,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [DATA_W-1:0] i_imm_ext,
  input  logic [DATA_W-1:0] i_pc_plus4,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_RegDst,
  output logic              o_branch,
  output logic              o_Memread,
  output logic              o_MemtoReg,
  output logic              o_MemWrite,
  output logic              o_AluSrc,
  output logic              o_RegWrite,
  output logic [3:0]        o_ALUop,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic [REG_W-1:0]  o_rs,
  output logic [REG_W-1:0]  o_rt,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_valid,
  output logic              o_stall,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  ctrl_t ctrl_in, ctrl_q;
  logic  hz, bubble;
  assign ctrl_in = '{reg_dst: i_RegDst, branch: i_branch, mem_read: i_Memread,
                     mem_to_reg: i_MemtoReg, alu_op: i_ALUop, mem_write: i_MemWrite,
                     alu_src: i_AluSrc, reg_write: i_RegWrite};
  assign o_RegDst   = ctrl_q.reg_dst;
  assign o_branch   = ctrl_q.branch;
  assign o_Memread  = ctrl_q.mem_read;
  assign o_MemtoReg = ctrl_q.mem_to_reg;
  assign o_ALUop    = ctrl_q.alu_op;
  assign o_MemWrite = ctrl_q.mem_write;
  assign o_AluSrc   = ctrl_q.alu_src;
  assign o_RegWrite = ctrl_q.reg_write;
  load_use_detect #(.REG_W(REG_W)) u_detect (
    .ex_valid   (o_valid),
    .ex_mem_read(ctrl_q.mem_read),
    .ex_rt      (o_rt),
    .id_valid   (i_valid),
    .id_rs      (i_rs),
    .id_rt      (i_rt),
    .hz         (hz)
  );
  // a flushed instruction never needs to wait, so flush masks the stall
  assign o_stall = hz & ~i_flush;
  assign bubble  = i_flush | hz;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      ctrl_q      <= CTRL_NOP;
      o_valid     <= 1'b0;
      o_rs_data   <= '0;
      o_rt_data   <= '0;
      o_imm_ext   <= '0;
      o_pc_plus4  <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_rd        <= '0;
      o_stall_cnt <= '0;
    end else begin
      ctrl_q      <= (bubble | ~i_valid) ? CTRL_NOP : ctrl_in;
      o_valid     <= i_valid & ~bubble;
      o_rs_data   <= bubble ? '0 : i_rs_data;
      o_rt_data   <= bubble ? '0 : i_rt_data;
      o_imm_ext   <= bubble ? '0 : i_imm_ext;
      o_pc_plus4  <= bubble ? '0 : i_pc_plus4;
      o_rs        <= bubble ? '0 : i_rs;
      o_rt        <= bubble ? '0 : i_rt;
      o_rd        <= bubble ? '0 : i_rd;
      if (o_stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a queue-based scoreboard for the ID/EX stage
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 6;
  typedef struct packed {
    logic valid, flush, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [3:0] alu_op;
    logic [DW-1:0] rs_data, rt_data, imm, pc4;
    logic [RW-1:0] rs, rt, rd;
  } vec_t;
  typedef struct packed {
    vec_t v;
    logic [CW-1:0] cnt;
  } exp_t;
  logic clk = 0, rst = 1;
  vec_t in = '0;
  logic o_RegDst, o_branch, o_Memread, o_MemtoReg, o_MemWrite, o_AluSrc, o_RegWrite;
  logic [3:0] o_ALUop;
  logic [DW-1:0] o_rs_data, o_rt_data, o_imm_ext, o_pc_plus4;
  logic [RW-1:0] o_rs, o_rt, o_rd;
  logic o_valid, o_stall;
  logic [CW-1:0] o_stall_cnt;
  int checks = 0, errors = 0;
  logic sq[$];
  exp_t rq[$];
  id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(in.valid), .i_flush(in.flush),
    .i_RegDst(in.reg_dst), .i_branch(in.branch), .i_Memread(in.mem_read),
    .i_MemtoReg(in.mem_to_reg), .i_MemWrite(in.mem_write), .i_AluSrc(in.alu_src),
    .i_RegWrite(in.reg_write), .i_ALUop(in.alu_op), .i_rs_data(in.rs_data),
    .i_rt_data(in.rt_data), .i_imm_ext(in.imm), .i_pc_plus4(in.pc4),
    .i_rs(in.rs), .i_rt(in.rt), .i_rd(in.rd),
    .o_RegDst(o_RegDst), .o_branch(o_branch), .o_Memread(o_Memread),
    .o_MemtoReg(o_MemtoReg), .o_MemWrite(o_MemWrite), .o_AluSrc(o_AluSrc),
    .o_RegWrite(o_RegWrite), .o_ALUop(o_ALUop), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_pc_plus4(o_pc_plus4),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_valid(o_valid), .o_stall(o_stall),
    .o_stall_cnt(o_stall_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t act();
    vec_t r = '0;
    r.valid = o_valid; r.reg_dst = o_RegDst; r.branch = o_branch; r.mem_read = o_Memread;
    r.mem_to_reg = o_MemtoReg; r.mem_write = o_MemWrite; r.alu_src = o_AluSrc;
    r.reg_write = o_RegWrite; r.alu_op = o_ALUop; r.rs_data = o_rs_data;
    r.rt_data = o_rt_data; r.imm = o_imm_ext; r.pc4 = o_pc_plus4;
    r.rs = o_rs; r.rt = o_rt; r.rd = o_rd;
    return r;
  endfunction
  function automatic vec_t v_lw(logic [RW-1:0] rs, logic [RW-1:0] rt, logic [DW-1:0] imm);
    vec_t r = '0;
    r.valid = 1; r.alu_src = 1; r.mem_read = 1; r.mem_to_reg = 1; r.reg_write = 1;
    r.rs = rs; r.rt = rt; r.imm = imm; r.rs_data = 32'h0000_1000; r.pc4 = 32'h0000_0040;
    return r;
  endfunction
  function automatic vec_t v_add(logic [RW-1:0] rs, logic [RW-1:0] rt, logic [RW-1:0] rd);
    vec_t r = '0;
    r.valid = 1; r.reg_dst = 1; r.reg_write = 1; r.alu_op = 4'b0010;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rs_data = 32'hA5A5_0000 | 32'(rs);
    r.rt_data = 32'h5A5A_0000 | 32'(rt); r.pc4 = 32'h0000_0044;
    return r;
  endfunction
  function automatic vec_t v_addi(logic [RW-1:0] rs, logic [RW-1:0] rt, logic [DW-1:0] imm);
    vec_t r = '0;
    r.valid = 1; r.alu_src = 1; r.reg_write = 1;
    r.rs = rs; r.rt = rt; r.imm = imm; r.rs_data = 32'h0000_0123; r.pc4 = 32'h0000_0048;
    return r;
  endfunction
  function automatic vec_t v_sw(logic [RW-1:0] rs, logic [RW-1:0] rt);
    vec_t r = '0;
    r.valid = 1; r.alu_src = 1; r.mem_write = 1;
    r.rs = rs; r.rt = rt; r.imm = 32'h8; r.rt_data = 32'hDEAD_BEEF; r.pc4 = 32'h0000_004C;
    return r;
  endfunction
  // expected EX contents: a capture mirrors the ID vector (control zeroed if not valid), a bubble is all zero
  task automatic step(input vec_t x, input logic exp_stall, input logic exp_bub, input logic [CW-1:0] exp_cnt);
    exp_t e;
    @(posedge clk); #2;
    in = x;
    e.v = x;
    e.v.flush = 0;
    if (!x.valid) {e.v.reg_dst, e.v.branch, e.v.mem_read, e.v.mem_to_reg, e.v.mem_write,
                   e.v.alu_src, e.v.reg_write, e.v.alu_op} = '0;
    if (exp_bub) e.v = '0;
    e.cnt = exp_cnt;
    sq.push_back(exp_stall);
    rq.push_back(e);
  endtask
  always @(negedge clk)
    if (sq.size() != 0) begin : mon_stall
      logic e;
      e = sq.pop_front();
      chk("stall", 192'(o_stall), 192'(e));
    end
  always @(posedge clk) begin
    #1;
    if (rq.size() != 0) begin : mon_regs
      exp_t e;
      e = rq.pop_front();
      chk("ex_regs", 192'(act()), 192'(e.v));
      chk("stall_cnt", 192'(o_stall_cnt), 192'(e.cnt));
    end
  end
  initial begin
    vec_t x;
    logic [CW-1:0] c;
    #1;
    chk("reset_regs", 192'(act()), 192'(0));
    chk("reset_cnt", 192'(o_stall_cnt), 192'(0));
    chk("reset_stall", 192'(o_stall), 192'(0));
    #11 rst = 0;
    step(v_add(1, 2, 3), 0, 0, 0);
    step(v_addi(3, 4, 32'hFFFF_FFFC), 0, 0, 0);
    x = v_add(8, 9, 10); x.valid = 0;
    step(x, 0, 0, 0);
    step(v_lw(2, 8, 4), 0, 0, 0);
    step(v_add(8, 9, 10), 1, 1, 1);
    step(v_add(8, 9, 10), 0, 0, 1);
    step(v_lw(2, 8, 4), 0, 0, 1);
    step(v_add(7, 8, 11), 1, 1, 2);
    step(v_add(7, 8, 11), 0, 0, 2);
    step(v_lw(2, 0, 4), 0, 0, 2);
    step(v_add(0, 0, 12), 0, 0, 2);
    step(v_sw(2, 8), 0, 0, 2);
    step(v_add(8, 8, 13), 0, 0, 2);
    step(v_lw(2, 8, 4), 0, 0, 2);
    x = v_add(8, 1, 1); x.valid = 0;
    step(x, 0, 0, 2);
    step(v_lw(2, 5, 0), 0, 0, 2);
    x = v_add(5, 6, 7); x.flush = 1;
    step(x, 0, 1, 2);
    x = v_addi(1, 2, 32'h3); x.flush = 1;
    step(x, 0, 1, 2);
    step(v_lw(8, 8, 0), 0, 0, 2);
    c = 2;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      c = (c == '1) ? c : c + 1'b1;
      step(v_lw(8, 8, 0), 1, 1, c);
      step(v_lw(8, 8, 0), 0, 0, c);
    end
    @(posedge clk); #3;
    chk("sat_cnt", 192'(o_stall_cnt), 192'({CW{1'b1}}));
    chk("queues_drained", 192'(sq.size() + rq.size()), 192'(0));
    in = v_add(1, 2, 3);
    @(posedge clk); #2;
    chk("rtype_loaded", 192'({o_valid, o_ALUop}), 192'({1'b1, 4'b0010}));
    #1 rst = 1;
    #1;
    chk("async_reset_regs", 192'(act()), 192'(0));
    chk("async_reset_cnt", 192'(o_stall_cnt), 192'(0));
    #1 rst = 0;
    in = v_lw(2, 8, 0);
    @(posedge clk); #2;
    in = v_add(8, 1, 1);
    #1;
    chk("pre_reset_stall", 192'(o_stall), 192'(1));
    rst = 1;
    #1;
    chk("reset_mid_stall", 192'(o_stall), 192'(0));
    chk("reset_mid_stall_regs", 192'(act()), 192'(0));
    #1 rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
